// File: rtl/mux_arb_rr.sv
// N-channel, W-bit registered mux with valid/ready on every port.
// Selection is either an external channel index (fixed) or round-robin arbitration.
module mux_arb_rr #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic [N*W-1:0]         in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned SW = $clog2(N);

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_chan_q, out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] last_q, last_d;

  logic          grant_vld;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic          acc;
  logic          xfer;
  logic [N-1:0]  in_ready_c;

  // Grant decision: fixed index, or first valid channel after the RR pointer (wrapping).
  always_comb begin
    grant_vld  = 1'b0;
    grant      = '0;
    grant_data = '0;
    if (!mode) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (SW'(k) == sel && in_valid[k]) begin
          grant_vld = 1'b1;
          grant     = SW'(k);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!grant_vld && in_valid[k] && SW'(k) > last_q) begin
          grant_vld = 1'b1;
          grant     = SW'(k);
        end
      end
      // Nothing above the pointer: wrap to the lowest valid channel.
      for (int unsigned k = 0; k < N; k++) begin
        if (!grant_vld && in_valid[k]) begin
          grant_vld = 1'b1;
          grant     = SW'(k);
        end
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (SW'(k) == grant) grant_data = in_data[k*W +: W];
    end
  end

  // Output stage free or draining this cycle; reset suppresses any handshake.
  always_comb begin
    acc        = !out_valid_q || out_ready;
    xfer       = grant_vld && acc && !reset;
    in_ready_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      in_ready_c[k] = xfer && (grant == SW'(k));
    end
  end

  // Next state of the output register and RR pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant;
      if (mode) last_d = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: cycle model predicts in_ready and output beats,
// expected beats are queued at input transfer and compared while held at the output.
module tb_mux_arb_rr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [7:0]   out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  logic         mode3;
  logic [1:0]   sel3;
  logic [23:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [7:0]   out_data3;
  logic [1:0]   out_chan3;
  logic         out_valid3;
  logic         out_ready3;

  int n_checks = 0;
  int n_err    = 0;

  beat_t      sb_q[$];
  logic       m_valid;
  logic [1:0] m_last;

  always #5 clk = ~clk;

  mux_arb_rr #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_arb_rr #(.N(3), .W(W)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock of the reference model: check outputs, predict handshake, advance.
  task automatic step();
    logic       acc, gv, xfer;
    logic [1:0] g;
    logic [3:0] exp_ready;
    beat_t      b;
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'(1), 32'(0));
      end else begin
        check_eq("out_data", 32'(out_data), 32'(sb_q[0].data));
        check_eq("out_chan", 32'(out_chan), 32'(sb_q[0].chan));
      end
    end
    acc = !m_valid || out_ready;
    gv  = 1'b0;
    g   = '0;
    if (!mode) begin
      if (in_valid[sel]) begin gv = 1'b1; g = sel; end
    end else begin
      for (int i = 1; i <= 4; i++) begin
        if (!gv && in_valid[(int'(m_last) + i) % 4]) begin
          gv = 1'b1;
          g  = 2'((int'(m_last) + i) % 4);
        end
      end
    end
    xfer      = gv && acc && !reset;
    exp_ready = xfer ? (4'b0001 << g) : 4'b0000;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    if (reset) begin
      m_valid = 1'b0;
      m_last  = 2'd3;
      sb_q.delete();
    end else begin
      if (m_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (xfer) begin
        b.chan = g;
        b.data = in_data[g*8 +: 8];
        sb_q.push_back(b);
        if (mode) m_last = g;
      end
      m_valid = xfer || (m_valid && !out_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_data   = 32'hD3C2B1A0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode3     = 1'b0;
    sel3      = 2'd0;
    in_data3  = 24'h332211;
    in_valid3 = 3'b000;
    out_ready3 = 1'b1;
    m_valid   = 1'b0;
    m_last    = 2'd3;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles with all channels valid
    steps(2);
    check_eq("rst_data", 32'(out_data), 32'(0));
    check_eq("rst_chan", 32'(out_chan), 32'(0));
    reset = 1'b0;

    // Round-robin fairness: 0,1,2,3,0,1,2,3 back to back
    steps(8);

    // Fixed select channel 2
    mode = 1'b0;
    sel  = 2'd2;
    steps(3);
    check_eq("fixed_data", 32'(out_data), 32'h00C2);

    // RR skip and wrap from last=0
    reset = 1'b1; steps(1); reset = 1'b0;
    mode = 1'b1;
    in_valid = 4'b0001; steps(1);
    in_valid = 4'b1001; steps(4);
    in_valid = 4'b0010; steps(1);
    in_valid = 4'b0000; steps(3);

    // Backpressure with held beat B1
    in_valid = 4'b0010; steps(1);
    out_ready = 1'b0; in_valid = 4'b1111; steps(3);
    check_eq("bp_hold", 32'(out_data), 32'h00B1);
    out_ready = 1'b1; steps(2);

    // Reset during a stall, then first grant is channel 0
    steps(1);
    out_ready = 1'b0; steps(1);
    reset = 1'b1; steps(1); reset = 1'b0;
    out_ready = 1'b1; steps(2);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 60) == 0);
      step();
    end
    reset = 1'b0;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    steps(2);

    // N=3 instance: out-of-range select yields no grant
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("n3_oor_ready", 32'(in_ready3), 32'(0));
      check_eq("n3_oor_valid", 32'(out_valid3), 32'(0));
      @(posedge clk); @(negedge clk);
    end
    sel3 = 2'd2;
    #1;
    check_eq("n3_sel2_ready", 32'(in_ready3), 32'(3'b100));
    @(posedge clk); @(negedge clk);
    in_valid3 = 3'b000;
    #1;
    check_eq("n3_valid", 32'(out_valid3), 32'(1));
    check_eq("n3_chan", 32'(out_chan3), 32'(2));
    check_eq("n3_data", 32'(out_data3), 32'h0033);
    @(posedge clk); @(negedge clk);
    #1;
    check_eq("n3_drain", 32'(out_valid3), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
